mem_access_unit: RTL

//  Memory-side partner of the multicycle CPU. Consumes the CPU request (R/W strobes, type, address, store data).

---
 rtl/mem_access_unit_if.sv | 39 +++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// CPU/RAM bus bundle for mem_access_unit.
//   slave  : the access unit's view (CPU request + RAM read data in,
//            load data/stall/error + RAM command out)
//   master : the environment's view (CPU and RAM side), directions mirrored
// Signals:
//   iMemR/iMemW       load / store strobes, held while oBusy=1
//   iMemType          0=word 1=half 2=byte 3=word
//   iMemAddr/iMemData byte address, store data (sub-word in low bits)
//   oMemData          right-aligned, zero-filled load data
//   oBusy/oAddrErr    stall to CPU, 1-cycle misalignment pulse
//   oRamEn/oRamWe/oRamAddr/oRamWData/iRamRData  single-port word RAM
interface mem_access_unit_if #(
  parameter int RAM_AW = 11,
  parameter int TYPE_W = 2
) ();
  logic              iMemR;
  logic              iMemW;
  logic [TYPE_W-1:0] iMemType;
  logic [31:0]       iMemAddr;
  logic [31:0]       iMemData;
  logic [31:0]       oMemData;
  logic              oBusy;
  logic              oAddrErr;
  logic              oRamEn;
  logic              oRamWe;
  logic [RAM_AW-1:0] oRamAddr;
  logic [31:0]       oRamWData;
  logic [31:0]       iRamRData;

  modport slave (
    input  iMemR, iMemW, iMemType, iMemAddr, iMemData, iRamRData,
    output oMemData, oBusy, oAddrErr, oRamEn, oRamWe, oRamAddr, oRamWData
  );

  modport master (
    output iMemR, iMemW, iMemType, iMemAddr, iMemData, iRamRData,
    input  oMemData, oBusy, oAddrErr, oRamEn, oRamWe, oRamAddr, oRamWData
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-side partner of the multicycle CPU. Turns CPU load/store requests
// into accesses on a single-port, whole-word, 1-cycle-read RAM, handling
// little-endian byte/half lanes and read-modify-write for sub-word stores.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-low
//   bus  mem_access_unit_if.slave (CPU request/response + RAM command/data)
// Timing: word store 0 stalls; load and sub-word store 2 stall cycles,
// load data valid from DONE and held until the next load completes.
module mem_access_unit #(
  parameter int RAM_AW = 11,
  parameter int TYPE_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_access_unit_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WAIT, DONE} state_t;

  state_t            state;
  logic [TYPE_W-1:0] type_q;
  logic [1:0]        lane_q;
  logic [31:0]       data_q;
  logic [RAM_AW-1:0] addr_q;
  logic [31:0]       mem_data_q;

  logic              is_half, is_byte, is_word, misaligned, req, accept;
  logic              ram_en, ram_we, busy, addr_err;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;

  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [TYPE_W-1:0] typ,
                                          input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    if (typ == TYPE_W'(2))
      r = (word >> {lane, 3'b000}) & 32'h0000_00FF;
    else if (typ == TYPE_W'(1))
      r = (word >> {lane[1], 4'b0000}) & 32'h0000_FFFF;
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word,
                                        input logic [31:0] data,
                                        input logic [TYPE_W-1:0] typ,
                                        input logic [1:0] lane);
    logic [31:0] mask;
    logic [4:0]  sh;
    mask = '1;
    sh   = '0;
    if (typ == TYPE_W'(2)) begin
      sh   = {lane, 3'b000};
      mask = 32'h0000_00FF << sh;
    end else if (typ == TYPE_W'(1)) begin
      sh   = {lane[1], 4'b0000};
      mask = 32'h0000_FFFF << sh;
    end
    return (word & ~mask) | ((data << sh) & mask);
  endfunction

  always_comb begin
    is_half    = (bus.iMemType == TYPE_W'(1));
    is_byte    = (bus.iMemType == TYPE_W'(2));
    is_word    = !is_half && !is_byte;
    misaligned = (is_half && bus.iMemAddr[0]) ||
                 (is_word && (bus.iMemAddr[1:0] != 2'b00));
    req        = bus.iMemR || bus.iMemW;
    accept     = (state == IDLE) && req && !misaligned;
  end

  // RAM command is combinational so a word store lands in the request cycle;
  // RMW_WAIT uses only registered request fields. Everything is gated by rst
  // so a reset cycle can never issue a RAM write.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    busy      = 1'b0;
    addr_err  = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = merge(bus.iRamRData, data_q, type_q, lane_q);
    if (rst) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (misaligned) begin
              addr_err = 1'b1;
            end else begin
              ram_en   = 1'b1;
              ram_addr = bus.iMemAddr[RAM_AW+1:2];
              if (bus.iMemW && is_word) begin
                ram_we    = 1'b1;
                ram_wdata = bus.iMemData;
              end else begin
                busy = 1'b1;
              end
            end
          end
        end
        RD_WAIT:  busy = 1'b1;
        RMW_WAIT: begin
          busy   = 1'b1;
          ram_en = 1'b1;
          ram_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mem_data_q <= '0;
      type_q     <= '0;
      lane_q     <= '0;
      data_q     <= '0;
      addr_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            type_q <= bus.iMemType;
            lane_q <= bus.iMemAddr[1:0];
            data_q <= bus.iMemData;
            addr_q <= bus.iMemAddr[RAM_AW+1:2];
            if (bus.iMemW)
              state <= is_word ? IDLE : RMW_WAIT;
            else
              state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          mem_data_q <= extract(bus.iRamRData, type_q, lane_q);
          state      <= DONE;
        end
        RMW_WAIT: state <= DONE;
        DONE:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign bus.oMemData  = mem_data_q;
  assign bus.oBusy     = busy;
  assign bus.oAddrErr  = addr_err;
  assign bus.oRamEn    = ram_en;
  assign bus.oRamWe    = ram_we;
  assign bus.oRamAddr  = ram_addr;
  assign bus.oRamWData = ram_wdata;

endmodule
